// File: rtl/mdu_scheduler.sv
// mdu_scheduler: round-robin arbitration of NREQ execute lanes onto one shared
// iterative multiply/divide unit, with a start/done handshake toward the MDU and
// a single-entry commit register toward the commit stage.
module mdu_scheduler #(
    parameter int NREQ = 4,
    parameter int DSTW = 7,
    parameter int OPW  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][OPW-1:0]   req_op,
    input  logic [NREQ-1:0][63:0]      req_a,
    input  logic [NREQ-1:0][63:0]      req_b,
    input  logic [NREQ-1:0][DSTW-1:0]  req_dst,
    output logic [NREQ-1:0]            req_grant,
    output logic                       mdu_start,
    output logic [OPW-1:0]             mdu_op,
    output logic [63:0]                mdu_a,
    output logic [63:0]                mdu_b,
    input  logic                       mdu_done,
    input  logic [63:0]                mdu_result,
    output logic                       cmt_valid,
    output logic [63:0]                cmt_data,
    output logic [DSTW-1:0]            cmt_dst,
    input  logic                       cmt_ready,
    output logic                       busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic            grant_fire;

    // Round-robin search: first valid lane starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin : arb_search
        int cand;
        // NOTE: every always_comb output gets a default before any branch, so no
        // path can leave it unassigned and infer a latch.
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(cand);
            end
        end
    end

    // A lane is consumed only from IDLE, and a flush suppresses it.
    assign grant_fire = (state == IDLE) && !flush && pick_found;
    assign req_grant  = grant_fire ? (NREQ'(1) << pick_idx) : '0;

    // Next-state logic; flush takes priority over every other transition.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    state_nx = START;
                end
            end
            START: begin
                state_nx = flush ? IDLE : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    // A result arriving together with the flush is simply dropped.
                    state_nx = mdu_done ? IDLE : DRAIN;
                end else if (mdu_done) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                // mdu_done here is a protocol error and is deliberately ignored.
                if (flush || cmt_ready) begin
                    state_nx = IDLE;
                end
            end
            DRAIN: begin
                // The killed operation's done retires the MDU; a flush alone
                // keeps waiting, as the MDU has not finished yet.
                if (mdu_done) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state <= state_nx;
            if (grant_fire) begin
                rr_ptr <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
            end
        end
    end

    // Operand latch on grant and result capture on a clean completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: these are a handful of flops, not a memory array, so clearing
            // them in reset is cheap and keeps the MDU/commit buses deterministic.
            mdu_op   <= '0;
            mdu_a    <= '0;
            mdu_b    <= '0;
            cmt_dst  <= '0;
            cmt_data <= '0;
        end else begin
            if (grant_fire) begin
                mdu_op  <= req_op[pick_idx];
                mdu_a   <= req_a[pick_idx];
                mdu_b   <= req_b[pick_idx];
                cmt_dst <= req_dst[pick_idx];
            end
            if ((state == WAIT) && mdu_done && !flush) begin
                cmt_data <= mdu_result;
            end
        end
    end

    // Handshake and status outputs decoded from the state.
    assign mdu_start = (state == START) && !flush;
    assign cmt_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mdu_scheduler.sv
// tb_mdu_scheduler: table-driven transactions through the scheduler plus
// hand-written flush, backpressure, round-robin and async-reset sequences.
module tb_mdu_scheduler;

    localparam int NREQ = 4;
    localparam int DSTW = 7;
    localparam int OPW  = 4;

    logic                      clk;
    logic                      reset;
    logic                      flush;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0][OPW-1:0]  req_op;
    logic [NREQ-1:0][63:0]     req_a;
    logic [NREQ-1:0][63:0]     req_b;
    logic [NREQ-1:0][DSTW-1:0] req_dst;
    logic [NREQ-1:0]           req_grant;
    logic                      mdu_start;
    logic [OPW-1:0]            mdu_op;
    logic [63:0]               mdu_a;
    logic [63:0]               mdu_b;
    logic                      mdu_done;
    logic [63:0]               mdu_result;
    logic                      cmt_valid;
    logic [63:0]               cmt_data;
    logic [DSTW-1:0]           cmt_dst;
    logic                      cmt_ready;
    logic                      busy;

    mdu_scheduler #(.NREQ(NREQ), .DSTW(DSTW), .OPW(OPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_dst    (req_dst),
        .req_grant  (req_grant),
        .mdu_start  (mdu_start),
        .mdu_op     (mdu_op),
        .mdu_a      (mdu_a),
        .mdu_b      (mdu_b),
        .mdu_done   (mdu_done),
        .mdu_result (mdu_result),
        .cmt_valid  (cmt_valid),
        .cmt_data   (cmt_data),
        .cmt_dst    (cmt_dst),
        .cmt_ready  (cmt_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row = one complete transaction from an idle scheduler.
    typedef struct {
        logic [3:0]  valid;   // req_valid mask held for the whole transaction
        int          lane;    // expected granted lane
        int          dly;     // cycles from mdu_start to mdu_done
        logic [63:0] res;     // result returned by the MDU
        int          stall;   // HOLD cycles with cmt_ready=0 before acceptance
    } vec_t;

    vec_t vecs [8];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    function automatic logic [3:0] onehot(input int lane);
        logic [3:0] one;
        one = 4'b0001;
        return one << lane;
    endfunction

    // Lane operands: a = 4+lane, b = 5+lane, op = lane, dst tag = 16+lane.
    task automatic run_txn(input vec_t v);
        req_valid = v.valid;
        cmt_ready = 1'b0;
        mdu_done  = 1'b0;
        settle();
        check("idle_busy", busy, 64'd0);
        check("grant", req_grant, onehot(v.lane));
        check("no_start_in_idle", mdu_start, 64'd0);
        tick();
        settle();
        check("start_pulse", mdu_start, 64'd1);
        check("no_grant_in_start", req_grant, 64'd0);
        check("mdu_op", mdu_op, 64'(v.lane));
        check("mdu_a", mdu_a, 64'(4 + v.lane));
        check("mdu_b", mdu_b, 64'(5 + v.lane));
        tick();
        for (int c = 1; c < v.dly; c++) begin
            settle();
            check("wait_no_start", mdu_start, 64'd0);
            check("wait_no_cmt", cmt_valid, 64'd0);
            check("wait_busy", busy, 64'd1);
            tick();
        end
        mdu_done   = 1'b1;
        mdu_result = v.res;
        settle();
        check("wait_no_grant", req_grant, 64'd0);
        tick();
        mdu_done   = 1'b0;
        mdu_result = '0;
        for (int s = 0; s <= v.stall; s++) begin
            cmt_ready = (s == v.stall);
            settle();
            check("hold_valid", cmt_valid, 64'd1);
            check("hold_data", cmt_data, v.res);
            check("hold_dst", cmt_dst, 64'(16 + v.lane));
            check("hold_no_grant", req_grant, 64'd0);
            check("hold_a_stable", mdu_a, 64'(4 + v.lane));
            tick();
        end
        cmt_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        req_valid  = '0;
        mdu_done   = 1'b0;
        mdu_result = '0;
        cmt_ready  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_op[i]  = OPW'(i);
            req_a[i]   = 64'(4 + i);
            req_b[i]   = 64'(5 + i);
            req_dst[i] = DSTW'(16 + i);
        end

        // rr_ptr evolution across rows: 0 -> 3 -> 0 -> 1 -> 1 -> 2 -> 0 -> 0 -> 2
        vecs[0] = '{valid: 4'b0100, lane: 2, dly: 5, res: 64'd42,    stall: 0};
        vecs[1] = '{valid: 4'b1111, lane: 3, dly: 1, res: 64'h1111,  stall: 0};
        vecs[2] = '{valid: 4'b1111, lane: 0, dly: 2, res: 64'hDEAD,  stall: 10};
        vecs[3] = '{valid: 4'b0001, lane: 0, dly: 3, res: 64'h5A5A,  stall: 0};
        vecs[4] = '{valid: 4'b1010, lane: 1, dly: 1, res: 64'hF00D,  stall: 2};
        vecs[5] = '{valid: 4'b1010, lane: 3, dly: 4, res: 64'hC0FFEE, stall: 0};
        vecs[6] = '{valid: 4'b1000, lane: 3, dly: 1, res: 64'h1,     stall: 1};
        vecs[7] = '{valid: 4'b0110, lane: 1, dly: 2, res: 64'hFFFF_FFFF_FFFF_FFFF, stall: 0};

        #12;
        check("rst_busy", busy, 64'd0);
        check("rst_grant", req_grant, 64'd0);
        check("rst_start", mdu_start, 64'd0);
        check("rst_cmt_valid", cmt_valid, 64'd0);
        check("rst_mdu_a", mdu_a, 64'd0);
        check("rst_cmt_data", cmt_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Flush two cycles into WAIT, done three cycles later (rr_ptr=2).
        req_valid = 4'b1111;
        settle();
        check("fw_grant", req_grant, 64'b0100);
        tick();
        req_valid = 4'b0000;
        settle();
        check("fw_start", mdu_start, 64'd1);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            mdu_done = (k == 2);
            settle();
            check("drain_busy", busy, 64'd1);
            check("drain_no_grant", req_grant, 64'd0);
            check("drain_no_cmt", cmt_valid, 64'd0);
            tick();
        end
        mdu_done = 1'b0;
        settle();
        check("drain_resume_grant", req_grant, 64'b1000);
        tick();

        // Flush in START: the start pulse is never issued (rr_ptr=0 afterwards).
        flush     = 1'b1;
        req_valid = 4'b0000;
        settle();
        check("fs_no_start", mdu_start, 64'd0);
        tick();
        flush = 1'b0;
        settle();
        check("fs_idle", busy, 64'd0);
        check("fs_no_start_after", mdu_start, 64'd0);

        // Flush together with done in WAIT: result dropped, back to IDLE.
        req_valid = 4'b1111;
        settle();
        check("fd_grant", req_grant, 64'b0001);
        tick();
        req_valid = 4'b0000;
        tick();
        flush      = 1'b1;
        mdu_done   = 1'b1;
        mdu_result = 64'hBAD;
        tick();
        flush    = 1'b0;
        mdu_done = 1'b0;
        settle();
        check("fd_no_cmt", cmt_valid, 64'd0);
        check("fd_idle", busy, 64'd0);

        // Stray done while IDLE must not move the FSM.
        mdu_done   = 1'b1;
        mdu_result = 64'h5555;
        tick();
        mdu_done = 1'b0;
        settle();
        check("stray_done_idle", busy, 64'd0);

        // Stray done in HOLD, then flush in HOLD with cmt_ready=1 (rr_ptr=1).
        req_valid = 4'b0001;
        settle();
        check("fh_grant", req_grant, 64'b0001);
        tick();
        req_valid = 4'b0000;
        tick();
        mdu_done   = 1'b1;
        mdu_result = 64'h77;
        tick();
        mdu_done = 1'b0;
        settle();
        check("fh_hold_valid", cmt_valid, 64'd1);
        check("fh_hold_data", cmt_data, 64'h77);
        mdu_done   = 1'b1;
        mdu_result = 64'h99;
        tick();
        mdu_done = 1'b0;
        settle();
        check("stray_done_hold_valid", cmt_valid, 64'd1);
        check("stray_done_hold_data", cmt_data, 64'h77);
        flush     = 1'b1;
        cmt_ready = 1'b1;
        tick();
        flush     = 1'b0;
        cmt_ready = 1'b0;
        settle();
        check("fh_cmt_drop", cmt_valid, 64'd0);
        check("fh_idle", busy, 64'd0);

        // Async reset between edges while in WAIT (rr_ptr=1, so lane 1 wins).
        req_valid = 4'b1111;
        settle();
        check("ar_grant", req_grant, 64'b0010);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("ar_busy", busy, 64'd0);
        check("ar_cmt_valid", cmt_valid, 64'd0);
        check("ar_mdu_start", mdu_start, 64'd0);
        check("ar_mdu_op", mdu_op, 64'd0);
        check("ar_mdu_a", mdu_a, 64'd0);
        check("ar_mdu_b", mdu_b, 64'd0);
        check("ar_cmt_dst", cmt_dst, 64'd0);
        check("ar_cmt_data", cmt_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // All lanes continuously valid from a fresh rr_ptr=0: order 0,1,2,3,0.
        begin : rr_run
            int  order [5];
            int  got;
            int  last;
            int  cyc;
            logic pend;
            order = '{0, 1, 2, 3, 0};
            got   = 0;
            last  = -100;
            cyc   = 0;
            pend  = 1'b0;
            cmt_ready = 1'b1;
            while (cyc < 80 && !(got == 5 && busy == 1'b0)) begin
                req_valid  = (got < 5) ? 4'b1111 : 4'b0000;
                mdu_done   = pend;
                mdu_result = 64'h1234;
                settle();
                pend = mdu_start;
                if (req_grant != '0) begin
                    check("rr_order", req_grant, onehot(order[got]));
                    check("rr_gap_ge4", 64'((cyc - last) >= 4), 64'd1);
                    last = cyc;
                    got++;
                end
                tick();
                cyc++;
            end
            check("rr_grant_count", 64'(got), 64'd5);
            check("rr_end_idle", busy, 64'd0);
            cmt_ready = 1'b0;
            mdu_done  = 1'b0;
            req_valid = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
